loop_replay_unit: RTL

- Reader end of the loop-buffer capture path. The capture FSM writes the instructions of a detected short backward-branch loop into this block, then commits the loop.
- The block then replays the stored loop to the decode stage, PC-tagged and wrapping at the loop end, while fetch is blocked.
- On a loop-exit mispredict it ends replay and issues a flush plus redirect PC.
- Sits between the capture FSM / fetch and the IF/ID register.

---
 rtl/loop_buffer_pkg.sv | 22 ++
 rtl/loop_replay_unit_if.sv | 38 +++
 rtl/loop_buffer_mem.sv | 33 +++
 rtl/loop_replay_unit.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/loop_buffer_pkg.sv
// Shared loop-buffer definitions.
// Used by the capture FSM and the replay unit.
package loop_buffer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRIME,
    ST_REPLAY,
    ST_EXIT
  } lb_state_e;

  localparam int INSTR_W = 32;
  localparam int PC_STEP = 4;

  function automatic logic [31:0] pc_at(
    input logic [31:0] base,
    input logic [31:0] idx
  );
    return base + idx * 32'(PC_STEP);
  endfunction

endpackage

// File: rtl/loop_replay_unit_if.sv
// Capture/replay bundle between capture FSM,
// decode and the loop replay unit.
interface loop_replay_unit_if;

  logic        cap_wr_en;
  logic [31:0] cap_instr;
  logic        cap_commit;
  logic        cap_abort;
  logic [31:0] cap_start_pc;
  logic        stall;
  logic        mispredict;
  logic        block_signal;
  logic        out_valid;
  logic [31:0] out_instruction;
  logic [31:0] out_pc;
  logic        flush;
  logic [31:0] new_pc;
  logic        cap_overflow;

  modport master (
    output cap_wr_en, cap_instr, cap_commit,
    output cap_abort, cap_start_pc,
    output stall, mispredict,
    input  block_signal, out_valid,
    input  out_instruction, out_pc,
    input  flush, new_pc, cap_overflow
  );

  modport slave (
    input  cap_wr_en, cap_instr, cap_commit,
    input  cap_abort, cap_start_pc,
    input  stall, mispredict,
    output block_signal, out_valid,
    output out_instruction, out_pc,
    output flush, new_pc, cap_overflow
  );

endinterface

// File: rtl/loop_buffer_mem.sv
// Loop buffer storage: one write port,
// one registered read port.
module loop_buffer_mem
  import loop_buffer_pkg::*;
#(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               we_i,
  input  logic [ADDR_W-1:0]  waddr_i,
  input  logic [INSTR_W-1:0] wdata_i,
  input  logic               re_i,
  input  logic [ADDR_W-1:0]  raddr_i,
  output logic [INSTR_W-1:0] rdata_o
);

  logic [INSTR_W-1:0] mem_q [DEPTH];
  logic [INSTR_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)     rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/loop_replay_unit.sv
// Replays a captured short loop to decode with PC
// tags; flushes and redirects on loop exit.
module loop_replay_unit
  import loop_buffer_pkg::*;
#(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic         clk,
  input  logic         reset,
  loop_replay_unit_if.slave bus
);

  lb_state_e         state_q;
  logic [ADDR_W:0]   wr_ptr_q;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W-1:0] rd_ptr_q;
  logic [31:0]       start_pc_q;
  logic [31:0]       out_pc_q;
  logic [31:0]       new_pc_q;
  logic              block_q;
  logic              valid_q;
  logic              flush_q;
  logic              ovf_q;

  logic              idle;
  logic              kill;
  logic              full;
  logic              wr_fire;
  logic              ovf_fire;
  logic              commit_ok;
  logic [ADDR_W:0]   commit_len;
  logic              rd_last;
  logic [ADDR_W-1:0] rd_nxt_d;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [31:0]       rd_data;

  assign idle = state_q == ST_IDLE;
  assign kill = bus.cap_abort | bus.mispredict;
  assign full = wr_ptr_q == (ADDR_W+1)'(DEPTH);

  assign wr_fire  = idle & bus.cap_wr_en & ~kill & ~full;
  assign ovf_fire = idle & bus.cap_wr_en & ~kill & full;

  // A write landing with the commit is part of the loop.
  assign commit_len = wr_ptr_q + (ADDR_W+1)'(wr_fire);
  assign commit_ok  = idle & bus.cap_commit & ~kill
                    & ~ovf_fire & (commit_len != '0);

  assign rd_last  = {1'b0, rd_ptr_q} == len_q - 1'b1;
  assign rd_nxt_d = rd_last ? '0 : rd_ptr_q + 1'b1;

  always_comb begin
    rd_en   = 1'b0;
    rd_addr = '0;
    if (state_q == ST_PRIME && !bus.mispredict) begin
      rd_en = 1'b1;
    end else if (state_q == ST_REPLAY && !bus.mispredict
                 && !bus.stall) begin
      rd_en   = 1'b1;
      rd_addr = rd_nxt_d;
    end
  end

  loop_buffer_mem #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_mem (
    .clk_i  (clk),
    .rst_i  (reset),
    .we_i   (wr_fire),
    .waddr_i(wr_ptr_q[ADDR_W-1:0]),
    .wdata_i(bus.cap_instr),
    .re_i   (rd_en),
    .raddr_i(rd_addr),
    .rdata_o(rd_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      len_q      <= '0;
      start_pc_q <= '0;
      out_pc_q   <= '0;
      new_pc_q   <= '0;
      block_q    <= 1'b0;
      valid_q    <= 1'b0;
      flush_q    <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      ovf_q    <= ovf_fire;
      flush_q  <= 1'b0;
      new_pc_q <= '0;
      unique case (state_q)
        ST_IDLE: begin
          if (kill || ovf_fire) begin
            wr_ptr_q <= '0;
          end else begin
            if (wr_fire) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (commit_ok) begin
              len_q      <= commit_len;
              start_pc_q <= bus.cap_start_pc;
              block_q    <= 1'b1;
              state_q    <= ST_PRIME;
            end
          end
        end
        ST_PRIME, ST_REPLAY: begin
          if (bus.mispredict) begin
            state_q  <= ST_EXIT;
            block_q  <= 1'b0;
            valid_q  <= 1'b0;
            flush_q  <= 1'b1;
            new_pc_q <= pc_at(start_pc_q, 32'(len_q));
          end else if (state_q == ST_PRIME) begin
            state_q  <= ST_REPLAY;
            rd_ptr_q <= '0;
            valid_q  <= 1'b1;
            out_pc_q <= start_pc_q;
          end else if (!bus.stall) begin
            rd_ptr_q <= rd_nxt_d;
            out_pc_q <= pc_at(start_pc_q, 32'(rd_nxt_d));
          end
        end
        ST_EXIT: begin
          wr_ptr_q <= '0;
          rd_ptr_q <= '0;
          state_q  <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.block_signal    = block_q;
  assign bus.out_valid       = valid_q;
  assign bus.out_instruction = rd_data;
  assign bus.out_pc          = out_pc_q;
  assign bus.flush           = flush_q;
  assign bus.new_pc          = new_pc_q;
  assign bus.cap_overflow    = ovf_q;

endmodule
